// File: rtl/lcd_rgb_fifo_reader.sv
// Parallel-RGB LCD timing generator fed from a 16-bit RGB565 FIFO; outputs lag the counters by one clock.
// Optional colour-bar test pattern (adds test_en) when LCD_TESTPAT_EN is defined.
module lcd_rgb_fifo_reader #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef LCD_TESTPAT_EN
  input  logic        test_en,
`endif
  input  logic [15:0] fifo_do,
  input  logic        fifo_empty,
  output logic        fifo_re,
  input  logic        underflow_clr,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYN_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYN_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BP + V_ACTIVE);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          act0;
  logic          tp_on;
  logic          uf_set;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, fs_q, fs_d, rd_q, uf_q, uf_d;
  logic [15:0]   pix;

  // Stage 0: free-running raster counters and the visible-window decode.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  assign act0 = (hcnt_q >= H_ACT_BEG) && (hcnt_q < H_ACT_END) &&
                (vcnt_q >= V_ACT_BEG) && (vcnt_q < V_ACT_END);

  // A starved pixel slot is skipped, never retried, so timing cannot stall.
  assign fifo_re = act0 & ~fifo_empty & ~tp_on;
  assign uf_set  = act0 & fifo_empty & ~tp_on;

  always_comb begin
    hs_d = ~(hcnt_q < H_SYN_END);
    vs_d = ~(vcnt_q < V_SYN_END);
    fs_d = (hcnt_q == '0) && (vcnt_q == '0);
    uf_d = uf_q;
    if (uf_set)
      uf_d = 1'b1;
    else if (underflow_clr)
      uf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      rd_q   <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= act0;
      fs_q   <= fs_d;
      rd_q   <= fifo_re;
      uf_q   <= uf_d;
    end
  end

`ifdef LCD_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [HW-1:0] hpos;
  logic [2:0]    bar;
  logic [15:0]   pat_d, pat_q;

  assign tp_on = test_en;

  // Bars: R on for 0,1,4,5; G on for 0..3; B on for even bars.
  always_comb begin
    hpos  = hcnt_q - H_ACT_BEG;
    bar   = 3'(hpos / HW'(BAR_W));
    pat_d = '0;
    if (tp_on && act0)
      pat_d = {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pat_q <= '0;
    else
      pat_q <= pat_d;
  end

  assign pix = rd_q ? fifo_do : pat_q;
`else
  assign tp_on = 1'b0;
  // NOREG FIFO: data read in stage 0 appears on fifo_do during stage 1.
  assign pix   = rd_q ? fifo_do : 16'h0000;
`endif

  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_de      = de_q;
  assign lcd_r       = pix[15:11];
  assign lcd_g       = pix[10:5];
  assign lcd_b       = pix[4:0];
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_lcd_rgb_fifo_reader.sv
// Bench for lcd_rgb_fifo_reader: small raster, behavioural NOREG FIFO, cycle model and pixel scoreboard.
`timescale 1ns/1ps
module tb_lcd_rgb_fifo_reader;

  localparam int H_SYNC = 1, H_BP = 1, H_FP = 1;
  localparam int V_ACTIVE = 2, V_FP = 1, V_SYNC = 1, V_BP = 1;
`ifdef LCD_TESTPAT_EN
  localparam int H_ACTIVE = 8;
`else
  localparam int H_ACTIVE = 4;
`endif
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int PIX     = H_ACTIVE * V_ACTIVE;

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fifo_do = 16'h0000;
  logic        fifo_empty = 1'b1;
  logic        underflow_clr = 1'b0;
  logic        test_en_tb = 1'b0;
  logic        fifo_re, lcd_hs, lcd_vs, lcd_de, frame_start, underflow;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;

  always #5 clk = ~clk;

  lcd_rgb_fifo_reader #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef LCD_TESTPAT_EN
    .test_en(test_en_tb),
`endif
    .fifo_do(fifo_do),
    .fifo_empty(fifo_empty),
    .fifo_re(fifo_re),
    .underflow_clr(underflow_clr),
    .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs),
    .lcd_de(lcd_de),
    .lcd_r(lcd_r),
    .lcd_g(lcd_g),
    .lcd_b(lcd_b),
    .frame_start(frame_start),
    .underflow(underflow)
  );

  // FIFO contents, scoreboard and cycle model
  logic [15:0] fifo_mem[$];
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int mh, mv;
  logic m_hs, m_vs, m_de, m_fs, m_uf, m_re;
  logic [15:0] m_pix;
  logic s_hs, s_vs, s_de, s_fs, s_uf, s_re;
  logic [15:0] s_rgb;
`ifdef LCD_TESTPAT_EN
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  function automatic logic is_act(int h, int v);
    return (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE) &&
           (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
  endfunction

  task automatic reset_model();
    mh = 0; mv = 0;
    m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0; m_fs = 1'b0; m_uf = 1'b0;
    m_pix = 16'h0000;
  endtask

  task automatic sample();
    #1;
    s_hs = lcd_hs; s_vs = lcd_vs; s_de = lcd_de; s_fs = frame_start;
    s_uf = underflow; s_re = fifo_re; s_rgb = {lcd_r, lcd_g, lcd_b};
    m_re = rst_n && is_act(mh, mv) && !fifo_empty && !test_en_tb;
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_mem.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: model advance at the edge, FIFO responds just after, sample at the falling edge.
  task automatic step();
    logic act;
    @(posedge clk);
    if (rst_n) begin
      act   = is_act(mh, mv);
      m_hs  = !(mh < H_SYNC);
      m_vs  = !(mv < V_SYNC);
      m_de  = act;
      m_fs  = (mh == 0) && (mv == 0);
      m_pix = 16'h0000;
      if (m_re && exp_q.size() > 0)
        m_pix = exp_q.pop_front();
`ifdef LCD_TESTPAT_EN
      else if (act && test_en_tb)
        m_pix = bars[(mh - H_SYNC - H_BP) / (H_ACTIVE / 8)];
`endif
      if (act && fifo_empty && !test_en_tb)
        m_uf = 1'b1;
      else if (underflow_clr)
        m_uf = 1'b0;
      mh = mh + 1;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv = (mv + 1) % V_TOTAL;
      end
    end
    #1;
    if (rst_n && s_re && fifo_mem.size() > 0)
      fifo_do = fifo_mem.pop_front();
    fifo_empty = (fifo_mem.size() == 0);
    underflow_clr = 1'b0;
    @(negedge clk);
    sample();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reset_model();
    repeat (3) step();
    n_checks++; if (s_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs got=%b exp=1", s_hs); end
    n_checks++; if (s_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs got=%b exp=1", s_vs); end
    n_checks++; if (s_de !== 1'b0) begin n_fail++; $display("FAIL reset_de got=%b exp=0", s_de); end
    n_checks++; if (s_rgb !== 16'h0) begin n_fail++; $display("FAIL reset_rgb got=%h exp=0000", s_rgb); end
    n_checks++; if (s_re !== 1'b0) begin n_fail++; $display("FAIL reset_re got=%b exp=0", s_re); end
    n_checks++; if (s_fs !== 1'b0) begin n_fail++; $display("FAIL reset_fs got=%b exp=0", s_fs); end
    n_checks++; if (s_uf !== 1'b0) begin n_fail++; $display("FAIL reset_uf got=%b exp=0", s_uf); end
    rst_n = 1'b1;
  endtask

  task automatic test_timing_empty();
    int de_cnt = 0, fs_cnt = 0, hs_low = 0, vs_low = 0, re_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++; if (s_hs !== m_hs) begin n_fail++; $display("FAIL timing_hs cyc=%0d got=%b exp=%b", i, s_hs, m_hs); end
      n_checks++; if (s_vs !== m_vs) begin n_fail++; $display("FAIL timing_vs cyc=%0d got=%b exp=%b", i, s_vs, m_vs); end
      n_checks++; if (s_de !== m_de) begin n_fail++; $display("FAIL timing_de cyc=%0d got=%b exp=%b", i, s_de, m_de); end
      n_checks++; if (s_fs !== m_fs) begin n_fail++; $display("FAIL timing_fs cyc=%0d got=%b exp=%b", i, s_fs, m_fs); end
      n_checks++; if (s_rgb !== 16'h0) begin n_fail++; $display("FAIL timing_rgb cyc=%0d got=%h exp=0000", i, s_rgb); end
      n_checks++; if (s_uf !== m_uf) begin n_fail++; $display("FAIL timing_uf cyc=%0d got=%b exp=%b", i, s_uf, m_uf); end
      de_cnt += int'(s_de === 1'b1);
      fs_cnt += int'(s_fs === 1'b1);
      hs_low += int'(s_hs === 1'b0);
      vs_low += int'(s_vs === 1'b0);
      re_cnt += int'(s_re !== 1'b0);
    end
    n_checks++; if (de_cnt != 2 * PIX) begin n_fail++; $display("FAIL timing_de_count got=%0d exp=%0d", de_cnt, 2 * PIX); end
    n_checks++; if (fs_cnt != 2) begin n_fail++; $display("FAIL timing_fs_count got=%0d exp=2", fs_cnt); end
    n_checks++; if (hs_low != 2 * V_TOTAL * H_SYNC) begin n_fail++; $display("FAIL timing_hs_low got=%0d exp=%0d", hs_low, 2 * V_TOTAL * H_SYNC); end
    n_checks++; if (vs_low != 2 * V_SYNC * H_TOTAL) begin n_fail++; $display("FAIL timing_vs_low got=%0d exp=%0d", vs_low, 2 * V_SYNC * H_TOTAL); end
    n_checks++; if (re_cnt != 0) begin n_fail++; $display("FAIL timing_re_count got=%0d exp=0", re_cnt); end
  endtask

  task automatic test_fifo_stream();
    int slot = 0, re_cnt = 0;
    // counters sit at frame top (blanking): clear the flag left by the empty frames
    underflow_clr = 1'b1;
    step();
    n_checks++; if (s_uf !== 1'b0) begin n_fail++; $display("FAIL clr_blank got=%b exp=0", s_uf); end
    push_word(16'hF800); push_word(16'h07E0); push_word(16'h001F); push_word(16'hFFFF);
    for (int i = 0; i < PIX - 4; i++) push_word(16'($urandom_range(1, 65535)));
    sample();
    for (int i = 0; i < FRAME - 1; i++) begin
      re_cnt += int'(s_re === 1'b1);
      step();
      if (m_de) slot++;
      n_checks++; if (s_de !== m_de) begin n_fail++; $display("FAIL stream_de cyc=%0d got=%b exp=%b", i, s_de, m_de); end
      n_checks++; if (s_rgb !== m_pix) begin n_fail++; $display("FAIL stream_rgb cyc=%0d got=%h exp=%h", i, s_rgb, m_pix); end
      n_checks++; if (s_re !== m_re) begin n_fail++; $display("FAIL stream_re cyc=%0d got=%b exp=%b", i, s_re, m_re); end
      n_checks++; if (s_uf !== 1'b0) begin n_fail++; $display("FAIL stream_uf cyc=%0d got=%b exp=0", i, s_uf); end
      if (m_de && slot == 1) begin
        n_checks++; if (s_rgb !== 16'hF800) begin n_fail++; $display("FAIL stream_first_px got=%h exp=f800", s_rgb); end
      end
      if (m_de && slot == 2) begin
        n_checks++; if (s_rgb !== 16'h07E0) begin n_fail++; $display("FAIL stream_second_px got=%h exp=07e0", s_rgb); end
      end
    end
    n_checks++; if (re_cnt != PIX) begin n_fail++; $display("FAIL stream_re_count got=%0d exp=%0d", re_cnt, PIX); end
  endtask

  task automatic test_underflow();
    int slot = 0;
    push_word(16'h1234); push_word(16'hABCD); push_word(16'h5A5A);
    sample();
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (m_de) slot++;
      n_checks++; if (s_de !== m_de) begin n_fail++; $display("FAIL uflow_de cyc=%0d got=%b exp=%b", i, s_de, m_de); end
      n_checks++; if (s_rgb !== m_pix) begin n_fail++; $display("FAIL uflow_rgb cyc=%0d got=%h exp=%h", i, s_rgb, m_pix); end
      n_checks++; if (s_uf !== m_uf) begin n_fail++; $display("FAIL uflow_flag cyc=%0d got=%b exp=%b", i, s_uf, m_uf); end
      n_checks++; if (s_re === 1'b1 && fifo_empty) begin n_fail++; $display("FAIL uflow_re_empty cyc=%0d got=1 exp=0", i); end
      if (m_de && slot == 3) begin
        n_checks++; if (s_uf !== 1'b0) begin n_fail++; $display("FAIL uflow_slot3_flag got=%b exp=0", s_uf); end
      end
      if (m_de && slot == 4) begin
        n_checks++; if (s_rgb !== 16'h0) begin n_fail++; $display("FAIL uflow_slot4_black got=%h exp=0000", s_rgb); end
        n_checks++; if (s_uf !== 1'b1) begin n_fail++; $display("FAIL uflow_slot4_flag got=%b exp=1", s_uf); end
      end
    end
  endtask

  task automatic test_underflow_clr();
    // at frame top (blanking) with the flag set
    underflow_clr = 1'b1;
    step();
    n_checks++; if (s_uf !== 1'b0) begin n_fail++; $display("FAIL clr_blanking got=%b exp=0", s_uf); end
    for (int i = 0; i < FRAME && !is_act(mh, mv); i++) step();
    n_checks++; if (!is_act(mh, mv)) begin n_fail++; $display("FAIL clr_wait_active got=timeout exp=active"); end
    step();
    n_checks++; if (s_uf !== 1'b1) begin n_fail++; $display("FAIL clr_reset_by_empty got=%b exp=1", s_uf); end
    for (int i = 0; i < FRAME && !is_act(mh, mv); i++) step();
    underflow_clr = 1'b1;
    step();
    n_checks++; if (s_uf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set got=%b exp=1", s_uf); end
    n_checks++; if (s_uf !== m_uf) begin n_fail++; $display("FAIL clr_model got=%b exp=%b", s_uf, m_uf); end
    while (!(mh == 0 && mv == 0)) step();
  endtask

  task automatic test_mid_frame_reset();
    int fs_cnt = 0, de_cnt = 0;
    for (int i = 0; i < FRAME && !(mv == 3 && mh == 2); i++) step();
    rst_n = 1'b0;
    reset_model();
    sample();
    n_checks++; if (s_hs !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hs got=%b exp=1", s_hs); end
    n_checks++; if (s_vs !== 1'b1) begin n_fail++; $display("FAIL mid_rst_vs got=%b exp=1", s_vs); end
    n_checks++; if (s_de !== 1'b0) begin n_fail++; $display("FAIL mid_rst_de got=%b exp=0", s_de); end
    n_checks++; if (s_rgb !== 16'h0) begin n_fail++; $display("FAIL mid_rst_rgb got=%h exp=0000", s_rgb); end
    n_checks++; if (s_re !== 1'b0) begin n_fail++; $display("FAIL mid_rst_re got=%b exp=0", s_re); end
    n_checks++; if (s_uf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_uf got=%b exp=0", s_uf); end
    step(); step();
    n_checks++; if (s_fs !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hold_fs got=%b exp=0", s_fs); end
    n_checks++; if (s_hs !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hold_hs got=%b exp=1", s_hs); end
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i == 0) begin
        n_checks++; if (s_fs !== 1'b1) begin n_fail++; $display("FAIL mid_rst_first_fs got=%b exp=1", s_fs); end
      end
      n_checks++; if (s_hs !== m_hs) begin n_fail++; $display("FAIL mid_rst_hs cyc=%0d got=%b exp=%b", i, s_hs, m_hs); end
      n_checks++; if (s_vs !== m_vs) begin n_fail++; $display("FAIL mid_rst_vs cyc=%0d got=%b exp=%b", i, s_vs, m_vs); end
      n_checks++; if (s_de !== m_de) begin n_fail++; $display("FAIL mid_rst_de cyc=%0d got=%b exp=%b", i, s_de, m_de); end
      n_checks++; if (s_uf !== m_uf) begin n_fail++; $display("FAIL mid_rst_uf cyc=%0d got=%b exp=%b", i, s_uf, m_uf); end
      fs_cnt += int'(s_fs === 1'b1);
      de_cnt += int'(s_de === 1'b1);
    end
    n_checks++; if (fs_cnt != 1) begin n_fail++; $display("FAIL mid_rst_fs_count got=%0d exp=1", fs_cnt); end
    n_checks++; if (de_cnt != PIX) begin n_fail++; $display("FAIL mid_rst_de_count got=%0d exp=%0d", de_cnt, PIX); end
  endtask

`ifdef LCD_TESTPAT_EN
  task automatic test_testpat();
    int slot = 0;
    test_en_tb = 1'b1;
    underflow_clr = 1'b1;
    fifo_mem.push_back(16'h1111);
    fifo_empty = 1'b0;
    sample();
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (m_de) slot++;
      n_checks++; if (s_rgb !== m_pix) begin n_fail++; $display("FAIL tp_rgb cyc=%0d got=%h exp=%h", i, s_rgb, m_pix); end
      n_checks++; if (s_re !== 1'b0) begin n_fail++; $display("FAIL tp_re cyc=%0d got=%b exp=0", i, s_re); end
      n_checks++; if (s_uf !== 1'b0) begin n_fail++; $display("FAIL tp_uf cyc=%0d got=%b exp=0", i, s_uf); end
      if (m_de && slot == 1) begin
        n_checks++; if (s_rgb !== 16'hFFFF) begin n_fail++; $display("FAIL tp_white got=%h exp=ffff", s_rgb); end
      end
      if (m_de && slot == H_ACTIVE) begin
        n_checks++; if (s_rgb !== 16'h0000) begin n_fail++; $display("FAIL tp_black got=%h exp=0000", s_rgb); end
      end
    end
    test_en_tb = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_model();
    @(negedge clk);
    sample();
    test_reset();
    test_timing_empty();
    test_fifo_stream();
    test_underflow();
    test_underflow_clr();
    test_mid_frame_reset();
`ifdef LCD_TESTPAT_EN
    test_testpat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
